// File: rtl/event_ring_pkg.sv
// Shared types for the event ring sequencer: FSM states, error codes and round counter width.
package event_ring_pkg;
   localparam int ROUND_W = 8;

   typedef enum logic [2:0] {ST_IDLE, ST_DELAY, ST_WAKE, ST_WAIT, ST_ERROR} state_e;
   typedef enum logic [1:0] {ERR_NONE, ERR_TIMEOUT, ERR_BAD_SUCC} err_e;
endpackage

// File: rtl/event_ring_timer.sv
// Loadable down-counter shared by the start delay and the per-visit timeout.
// expired flags the last counted cycle; a zero load parks the counter and never expires.
module event_ring_timer
   import event_ring_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         expired
);
   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             cnt <= '0;
      else if (load)          cnt <= value;
      else if (cnt != '0)     cnt <= cnt - 1'b1;
   end

   assign expired = (cnt == W'(1));
endmodule

// File: rtl/event_ring_sequencer.sv
// Token-passing sequencer: wakes one channel at a time, follows the latched successor
// table on each done, counts returns to first_ch and stops after ROUNDS of them.
module event_ring_sequencer
   import event_ring_pkg::*;
#(
   parameter int N_CH        = 3,
   parameter int START_DELAY = 16,
   parameter int ROUNDS      = 2,
   parameter int TIMEOUT     = 255,
   parameter int IDX_W       = $clog2(N_CH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    abort,
   input  logic [IDX_W-1:0]        first_ch,
   input  logic [N_CH*IDX_W-1:0]   next_sel,
   input  logic [N_CH-1:0]         done,
   output logic [N_CH-1:0]         wake,
   output logic [IDX_W-1:0]        cur_ch,
   output logic [ROUND_W-1:0]      round_cnt,
   output logic                    busy,
   output logic                    finished,
   output logic [1:0]              err_code,
   output logic                    stray_done
);
   localparam int MAXV  = (START_DELAY > TIMEOUT) ? START_DELAY : TIMEOUT;
   localparam int CNT_W = (MAXV < 2) ? 1 : $clog2(MAXV + 1);
   // One extra bit so a power-of-two N_CH still compares correctly.
   localparam logic [IDX_W:0] NCH = (IDX_W + 1)'(N_CH);

   state_e                      state, nstate;
   err_e                        err;
   logic [N_CH-1:0][IDX_W-1:0]  tbl;
   logic [IDX_W-1:0]            fst, nxt, wake_ch;
   logic [ROUND_W-1:0]          rc_new;
   logic [CNT_W-1:0]            t_val;
   logic                        t_load, t_exp, bad, accept, fin, to_err, do_start;

   event_ring_timer #(.W(CNT_W)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (t_load),
      .value   (t_val),
      .expired (t_exp)
   );

   // An out-of-range first_ch is rejected too: it could never be woken.
   always_comb begin
      bad = ({1'b0, first_ch} >= NCH);
      for (int i = 0; i < N_CH; i++)
         if ({1'b0, next_sel[i*IDX_W +: IDX_W]} >= NCH) bad = 1'b1;
   end

   assign nxt      = tbl[cur_ch];
   assign rc_new   = (nxt == fst && round_cnt != '1) ? round_cnt + 1'b1 : round_cnt;
   assign busy     = (state == ST_DELAY) || (state == ST_WAKE) || (state == ST_WAIT);
   assign err_code = err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= nstate;
   end

   always_comb begin
      nstate   = state;
      do_start = 1'b0;
      accept   = 1'b0;
      fin      = 1'b0;
      to_err   = 1'b0;
      t_load   = 1'b0;
      t_val    = '0;
      wake_ch  = cur_ch;
      case (state)
         ST_IDLE, ST_ERROR: if (start) begin
            do_start = 1'b1;
            wake_ch  = first_ch;
            if (bad) nstate = ST_IDLE;
            else if (START_DELAY == 0) begin
               nstate = ST_WAKE;
               t_load = 1'b1;
               t_val  = CNT_W'(TIMEOUT);
            end else begin
               nstate = ST_DELAY;
               t_load = 1'b1;
               t_val  = CNT_W'(START_DELAY);
            end
         end
         ST_DELAY: if (t_exp) begin
            nstate = ST_WAKE;
            t_load = 1'b1;
            t_val  = CNT_W'(TIMEOUT);
         end
         ST_WAKE, ST_WAIT: begin
            // The timeout is reloaded as the wake goes out, so WAKE itself counts.
            if (done[cur_ch]) begin
               accept = 1'b1;
               if (rc_new == ROUND_W'(ROUNDS)) begin
                  fin    = 1'b1;
                  nstate = ST_IDLE;
               end else begin
                  nstate  = ST_WAKE;
                  wake_ch = nxt;
                  t_load  = 1'b1;
                  t_val   = CNT_W'(TIMEOUT);
               end
            end else if (t_exp) begin
               nstate = ST_ERROR;
               to_err = 1'b1;
            end else nstate = ST_WAIT;
         end
         default: nstate = ST_IDLE;
      endcase
      if (abort) begin
         nstate   = ST_IDLE;
         do_start = 1'b0;
         accept   = 1'b0;
         fin      = 1'b0;
         to_err   = 1'b0;
         t_load   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wake       <= '0;
         cur_ch     <= '0;
         round_cnt  <= '0;
         finished   <= 1'b0;
         err        <= ERR_NONE;
         stray_done <= 1'b0;
         fst        <= '0;
         tbl        <= '0;
      end else begin
         finished <= fin;
         wake     <= (nstate == ST_WAKE) ? (N_CH'(1) << wake_ch) : '0;
         if (do_start) begin
            fst        <= first_ch;
            tbl        <= next_sel;
            cur_ch     <= first_ch;
            round_cnt  <= '0;
            stray_done <= 1'b0;
            err        <= bad ? ERR_BAD_SUCC : ERR_NONE;
         end else if (busy && |(done & ~(N_CH'(1) << cur_ch))) begin
            stray_done <= 1'b1;
         end
         if (accept) begin
            round_cnt <= rc_new;
            if (!fin) cur_ch <= nxt;
         end
         if (to_err) err <= ERR_TIMEOUT;
      end
   end
endmodule

// File: tb/tb_event_ring_sequencer.sv
// Bench for event_ring_sequencer: two instances (start delay 4 and 0) against a
// time-based model that tracks when each wake is due and when each visit times out.
module tb_event_ring_sequencer;
   localparam int SD_A = 4;
   localparam int SD_B = 0;
   localparam int TO   = 8;
   localparam int RND  = 2;
   localparam logic [5:0] TBL_OK  = 6'b00_10_01;   // 0->1, 1->2, 2->0
   localparam logic [5:0] TBL_BAD = 6'b00_11_01;   // 0->1, 1->3, 2->0

   logic clk, rst_n;
   logic [1:0]      st_v, ab_v;
   logic [1:0][1:0] fc_v;
   logic [1:0][5:0] ns_v;
   logic [1:0][2:0] dn_v;

   logic [2:0] wake_a, wake_b;
   logic [1:0] cur_a, cur_b, err_a, err_b;
   logic [7:0] rc_a, rc_b;
   logic busy_a, busy_b, fin_a, fin_b, stray_a, stray_b;

   logic [1:0][2:0] wake_o;
   logic [1:0][1:0] cur_o, err_o;
   logic [1:0][7:0] rc_o;
   logic [1:0]      busy_o, fin_o, stray_o;
   assign wake_o  = {wake_b, wake_a};
   assign cur_o   = {cur_b, cur_a};
   assign err_o   = {err_b, err_a};
   assign rc_o    = {rc_b, rc_a};
   assign busy_o  = {busy_b, busy_a};
   assign fin_o   = {fin_b, fin_a};
   assign stray_o = {stray_b, stray_a};

   event_ring_sequencer #(.N_CH(3), .START_DELAY(SD_A), .ROUNDS(RND), .TIMEOUT(TO)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(st_v[0]), .abort(ab_v[0]), .first_ch(fc_v[0]),
      .next_sel(ns_v[0]), .done(dn_v[0]), .wake(wake_a), .cur_ch(cur_a), .round_cnt(rc_a),
      .busy(busy_a), .finished(fin_a), .err_code(err_a), .stray_done(stray_a));

   event_ring_sequencer #(.N_CH(3), .START_DELAY(SD_B), .ROUNDS(RND), .TIMEOUT(TO)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(st_v[1]), .abort(ab_v[1]), .first_ch(fc_v[1]),
      .next_sel(ns_v[1]), .done(dn_v[1]), .wake(wake_b), .cur_ch(cur_b), .round_cnt(rc_b),
      .busy(busy_b), .finished(fin_b), .err_code(err_b), .stray_done(stray_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: a run is "active" from a good start until finish/timeout/abort; the holder
   // is woken exactly in cycle wake_due and may answer from then until wake_due+TO-1.
   typedef struct packed {
      int         run;
      int         holder;
      int         first;
      logic [5:0] tbl;
      int         wake_due;
      int         fin_at;
      int         rounds;
      int         err;
      int         stray;
   } mst_t;

   mst_t m [2];
   int   mcyc;

   always @(posedge clk or negedge rst_n) begin
      mst_t s;
      int   c, nx;
      logic bad;
      if (!rst_n) begin
         s = '0;
         s.fin_at = -1;
         s.wake_due = -1;
         for (int k = 0; k < 2; k++) m[k] <= s;
         mcyc <= 0;
      end else begin
         c = mcyc;
         for (int k = 0; k < 2; k++) begin
            s = m[k];
            if (s.run != 0 && (dn_v[k] & ~(3'b001 << s.holder)) != 3'b000) s.stray = 1;
            if (ab_v[k]) s.run = 0;
            else if (s.run == 0) begin
               if (st_v[k]) begin
                  bad = (fc_v[k] == 2'd3);
                  for (int i = 0; i < 3; i++) if (ns_v[k][2*i +: 2] == 2'd3) bad = 1'b1;
                  s.err = 0; s.stray = 0; s.rounds = 0;
                  s.first = int'(fc_v[k]); s.holder = int'(fc_v[k]); s.tbl = ns_v[k];
                  if (bad) s.err = 2;
                  else begin
                     s.run = 1;
                     s.wake_due = c + 1 + ((k == 0) ? SD_A : SD_B);
                  end
               end
            end else if (c >= s.wake_due) begin
               if (dn_v[k][s.holder]) begin
                  nx = int'(s.tbl[2*s.holder +: 2]);
                  if (nx == s.first && s.rounds < 255) s.rounds = s.rounds + 1;
                  if (s.rounds == RND) begin
                     s.run = 0;
                     s.fin_at = c + 1;
                  end else begin
                     s.holder = nx;
                     s.wake_due = c + 1;
                  end
               end else if (c == s.wake_due + TO - 1) begin
                  s.run = 0;
                  s.err = 1;
               end
            end
            m[k] <= s;
         end
         mcyc <= c + 1;
      end
   end

   int checks = 0;
   int failures = 0;
   int wq[$];
   int wfirst;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      int ew;
      if (rst_n) begin
         for (int k = 0; k < 2; k++) begin
            ew = (m[k].run != 0 && mcyc == m[k].wake_due) ? (1 << m[k].holder) : 0;
            chk($sformatf("wake%0d", k),   32'(wake_o[k]),  ew);
            chk($sformatf("busy%0d", k),   32'(busy_o[k]),  m[k].run);
            chk($sformatf("cur%0d", k),    32'(cur_o[k]),   m[k].holder);
            chk($sformatf("rounds%0d", k), 32'(rc_o[k]),    m[k].rounds);
            chk($sformatf("fin%0d", k),    32'(fin_o[k]),   (mcyc == m[k].fin_at) ? 1 : 0);
            chk($sformatf("err%0d", k),    32'(err_o[k]),   m[k].err);
            chk($sformatf("stray%0d", k),  32'(stray_o[k]), m[k].stray);
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      compare_all();
   endtask

   // Answers n wakes on instance k with done lat cycles after each wake; optionally pulses a
   // stray done on the wake cycle of stray_on, and a start alongside the done of visit poke.
   task automatic serve(input int k, input int lat, input int n, input int stray_on,
                        input int stray_ch, input int poke);
      int t, ch;
      wq.delete();
      for (int v = 0; v < n; v++) begin
         t = 0;
         while (wake_o[k] == 3'b000 && t < 60) begin tick(); t++; end
         if (wake_o[k] == 3'b000) begin
            checks++; failures++;
            $display("FAIL serve_wait dut=%0d visit=%0d no wake within 60 cycles", k, v);
            return;
         end
         ch = 0;
         for (int i = 0; i < 3; i++) if (wake_o[k][i]) ch = i;
         if (v == 0) wfirst = mcyc;
         wq.push_back(ch);
         if (ch == stray_on) begin
            dn_v[k][stray_ch] = 1'b1;
            tick();
            dn_v[k] = '0;
            repeat (lat - 1) tick();
         end else repeat (lat) tick();
         dn_v[k][ch] = 1'b1;
         if (v == poke) st_v[k] = 1'b1;
         tick();
         dn_v[k] = '0;
         st_v[k] = 1'b0;
      end
   endtask

   initial begin
      int s, w, e, cnt, t;
      int ord[6] = '{0, 1, 2, 0, 1, 2};
      rst_n = 1'b0;
      st_v = '0; ab_v = '0; fc_v = '0; ns_v = '0; dn_v = '0;
      repeat (2) tick();
      for (int k = 0; k < 2; k++)
         chk($sformatf("reset_outs%0d", k),
             32'({wake_o[k], cur_o[k], rc_o[k], busy_o[k], fin_o[k], err_o[k], stray_o[k]}), 0);
      rst_n = 1'b1;
      repeat (2) tick();

      // 1: two full rounds, done two cycles after each wake
      fc_v[0] = 2'd0; ns_v[0] = TBL_OK; st_v[0] = 1'b1; s = mcyc;
      tick(); st_v[0] = 1'b0;
      serve(0, 2, 6, -1, 0, -1);
      chk("t1_first_wake", 32'(wfirst - s), 5);
      chk("t1_visits", 32'(wq.size()), 6);
      for (int i = 0; i < 6 && i < wq.size(); i++) chk($sformatf("t1_order%0d", i), 32'(wq[i]), 32'(ord[i]));
      chk("t1_fin", 32'(fin_o[0]), 1);
      chk("t1_fin_cyc", 32'(mcyc - s), 23);
      chk("t1_rounds", 32'(rc_o[0]), 2);
      chk("t1_stray", 32'(stray_o[0]), 0);
      repeat (3) tick();

      // 2: no done at all -> timeout eight cycles after the wake
      st_v[0] = 1'b1; tick(); st_v[0] = 1'b0;
      t = 0;
      while (wake_o[0] == 3'b000 && t < 30) begin tick(); t++; end
      w = mcyc;
      chk("t2_wake0", 32'(wake_o[0]), 1);
      t = 0;
      while (err_o[0] == 2'd0 && t < 40) begin tick(); t++; end
      e = mcyc;
      chk("t2_err_delay", 32'(e - w), 8);
      chk("t2_err", 32'(err_o[0]), 1);
      chk("t2_busy", 32'(busy_o[0]), 0);
      cnt = 0;
      repeat (12) begin tick(); if (wake_o[0] != 3'b000) cnt++; end
      chk("t2_no_wake", 32'(cnt), 0);

      // 3: bad successor entry, started from the error state
      ns_v[0] = TBL_BAD; st_v[0] = 1'b1; tick(); st_v[0] = 1'b0;
      chk("t3_err", 32'(err_o[0]), 2);
      chk("t3_busy", 32'(busy_o[0]), 0);
      cnt = 0;
      repeat (8) begin tick(); if (wake_o[0] != 3'b000 || busy_o[0]) cnt++; end
      chk("t3_quiet", 32'(cnt), 0);

      // 4: stray done[2] while channel 1 holds the token
      ns_v[0] = TBL_OK; st_v[0] = 1'b1; s = mcyc;
      tick(); st_v[0] = 1'b0;
      serve(0, 2, 6, 1, 2, -1);
      chk("t4_stray", 32'(stray_o[0]), 1);
      chk("t4_visits", 32'(wq.size()), 6);
      for (int i = 0; i < 6 && i < wq.size(); i++) chk($sformatf("t4_order%0d", i), 32'(wq[i]), 32'(ord[i]));
      chk("t4_fin_cyc", 32'(mcyc - s), 23);
      repeat (3) tick();

      // 5: no start delay, done in the wake cycle, a start while busy (with a different first_ch)
      fc_v[1] = 2'd0; ns_v[1] = TBL_OK; st_v[1] = 1'b1; s = mcyc;
      tick(); st_v[1] = 1'b0; fc_v[1] = 2'd1;
      serve(1, 0, 6, -1, 0, 2);
      chk("t5_first_wake", 32'(wfirst - s), 1);
      chk("t5_visits", 32'(wq.size()), 6);
      for (int i = 0; i < 6 && i < wq.size(); i++) chk($sformatf("t5_order%0d", i), 32'(wq[i]), 32'(ord[i]));
      chk("t5_fin_cyc", 32'(mcyc - s), 7);
      chk("t5_fin", 32'(fin_o[1]), 1);
      repeat (3) tick();

      // 6a: abort while waiting for done
      st_v[0] = 1'b1; tick(); st_v[0] = 1'b0;
      t = 0;
      while (wake_o[0] == 3'b000 && t < 30) begin tick(); t++; end
      repeat (2) tick();
      ab_v[0] = 1'b1; tick(); ab_v[0] = 1'b0;
      chk("t6_abort_busy", 32'(busy_o[0]), 0);
      cnt = 0;
      repeat (30) begin tick(); if (fin_o[0] || wake_o[0] != 3'b000) cnt++; end
      chk("t6_abort_quiet", 32'(cnt), 0);

      // 6b: asynchronous reset in the middle of a wake cycle
      fc_v[1] = 2'd2; st_v[1] = 1'b1; tick(); st_v[1] = 1'b0;
      chk("t6_wake_pre", 32'(wake_o[1]), 4);
      chk("t6_cur_pre", 32'(cur_o[1]), 2);
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++)
         chk($sformatf("t6_async_rst%0d", k),
             32'({wake_o[k], cur_o[k], rc_o[k], busy_o[k], fin_o[k], err_o[k], stray_o[k]}), 0);
      tick();
      rst_n = 1'b1;
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
